// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/redirect sequencing for the 5-stage pipeline, with a debug halt/drain/step FSM
// and saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rd,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_use_rs1,
  input  logic             ifid_use_rs2,
  input  logic             exmem_br_taken,
  input  logic             halt_req,
  input  logic             step_req,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [1:0] StRun    = 2'd0;
  localparam logic [1:0] StDrain  = 2'd1;
  localparam logic [1:0] StHalted = 2'd2;
  localparam logic [1:0] StStep   = 2'd3;

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DrainInit = DW'(DRAIN_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic             step_prev_q;
  logic [CNT_W-1:0] stall_count_q, flush_count_q;

  logic lu, active, stall, step_edge;

  assign lu = idex_memread && (idex_rd != 5'd0) &&
              ((ifid_use_rs1 && (idex_rd == ifid_rs1)) ||
               (ifid_use_rs2 && (idex_rd == ifid_rs2)));

  assign active    = (state_q == StRun) || (state_q == StStep);
  // A taken redirect overrides the load-use stall for that cycle.
  assign stall     = active && lu && !exmem_br_taken;
  assign step_edge = step_req && !step_prev_q;

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      StRun: begin
        if (halt_req) begin
          state_d     = StDrain;
          drain_cnt_d = DrainInit;
        end
      end
      StDrain: begin
        if (!halt_req) begin
          state_d = StRun;
        end else if (drain_cnt_q == '0) begin
          state_d = StHalted;
        end else begin
          drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end
      StHalted: begin
        if (!halt_req) begin
          state_d = StRun;
        end else if (step_edge) begin
          state_d = StStep;
        end
      end
      default: begin
        // Hold STEP until the stepped instruction has actually issued.
        if (!stall) begin
          state_d     = StDrain;
          drain_cnt_d = DrainInit;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StRun;
      drain_cnt_q   <= '0;
      step_prev_q   <= 1'b0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      step_prev_q <= step_req;
      if (stall && (stall_count_q != '1)) begin
        stall_count_q <= stall_count_q + CNT_W'(1);
      end
      if (exmem_br_taken && (flush_count_q != '1)) begin
        flush_count_q <= flush_count_q + CNT_W'(1);
      end
    end
  end

  // Outputs are forced quiet while reset is held.
  assign pc_write    = reset && (exmem_br_taken || (active && !stall));
  assign ifid_write  = reset && active && !stall;
  assign idex_bubble = reset && (!active || stall);
  assign flush_ifid  = reset && exmem_br_taken;
  assign flush_idex  = reset && exmem_br_taken;
  assign flush_exmem = reset && exmem_br_taken;
  assign halted      = (state_q == StHalted);
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule
